// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a valid/ready handshake on both sides and an optional skid entry.
// With SKID=1, in_ready comes straight from a flop, so there is no combinational stall path between stages.
module pipe_skid_reg #(
  parameter int DW   = 38,
  parameter bit SKID = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy
);

  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          main_v_q, main_v_d;
  logic          skid_v_q, skid_v_d;
  logic          in_fire, out_fire;

  assign in_ready  = SKID ? !skid_v_q : (!main_v_q || out_ready);
  assign out_valid = main_v_q;
  assign out_data  = main_q;
  assign occupancy = 2'(main_v_q) + 2'(skid_v_q);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_v_q && out_ready;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path leaves one unassigned (no latch).
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;

    if (SKID) begin
      if (!main_v_q) begin
        if (in_fire) begin
          main_d   = in_data;
          main_v_d = 1'b1;
        end
      end else if (!skid_v_q) begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d   = in_data;
          skid_v_d = 1'b1;
        end else if (out_fire) begin
          main_v_d = 1'b0;
        end
      end else if (out_fire) begin
        // FULL: the skid beat is older than anything upstream, so it moves into main.
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end
    end else begin
      if (in_fire) begin
        main_d   = in_data;
        main_v_d = 1'b1;
      end else if (out_fire) begin
        main_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // NOTE: data registers are cleared too, so out_data reads 0 right after rst/flush instead of stale data.
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: one SKID=1 and one SKID=0 instance share clk/rst/flush; a queue
// per instance records accepted beats and is compared against every delivered beat.
module tb_pipe_skid_reg;

  localparam int DW = 38;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          iv   [2];
  logic          ir   [2];
  logic [DW-1:0] id   [2];
  logic          ov   [2];
  logic          ordy [2];
  logic [DW-1:0] od   [2];
  logic [1:0]    occ  [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] sbq0[$];
  logic [DW-1:0] sbq1[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(.DW(DW), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .occupancy(occ[0])
  );

  pipe_skid_reg #(.DW(DW), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .occupancy(occ[1])
  );

  function automatic int sb_size(int k);
    return (k == 0) ? sbq0.size() : sbq1.size();
  endfunction

  function automatic void sb_push(int k, logic [DW-1:0] d);
    if (k == 0) sbq0.push_back(d);
    else        sbq1.push_back(d);
  endfunction

  function automatic logic [DW-1:0] sb_pop(int k);
    if (k == 0) return sbq0.pop_front();
    return sbq1.pop_front();
  endfunction

  function automatic void sb_clear(int k);
    if (k == 0) sbq0.delete();
    else        sbq1.delete();
  endfunction

  // One clock cycle: settle inputs, score handshakes for both instances, advance past the edge.
  task automatic tick();
    logic [DW-1:0] exp_d;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst && ov[k] && ordy[k]) begin
        n_tests++;
        if (sb_size(k) == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected[skid=%0d] got %h, required no beat", k, od[k]);
        end else begin
          exp_d = sb_pop(k);
          if (od[k] !== exp_d) begin
            n_fail++;
            $display("FAIL sb_order[skid=%0d] got %h, required %h", k, od[k], exp_d);
          end
        end
      end
      if (rst || flush) sb_clear(k);
      else if (iv[k] && ir[k]) sb_push(k, id[k]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0;
      id[k] = '0;
      ordy[k] = 1'b1;
    end
    flush = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int c = 0; c < 4; c++) tick();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (occ[k] !== 2'd0 || sb_size(k) != 0) begin
        n_fail++;
        $display("FAIL drain[skid=%0d] got occ=%0d pending=%0d, required 0/0", k, occ[k], sb_size(k));
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b1;
      id[k] = DW'(8'h5A);
    end
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (ov[k] !== 1'b0 || od[k] !== '0 || occ[k] !== 2'd0 || ir[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset[skid=%0d] got v=%b d=%h occ=%0d rdy=%b, required 0/0/0/1",
                 k, ov[k], od[k], occ[k], ir[k]);
      end
    end
    idle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream(int k);
    idle();
    for (int i = 1; i <= 10; i++) begin
      iv[k] = 1'b1;
      id[k] = DW'(i);
      tick();
      n_tests++;
      if (ov[k] !== 1'b1 || od[k] !== DW'(i)) begin
        n_fail++;
        $display("FAIL stream[skid=%0d] beat %0d got v=%b d=%h, required v=1 d=%h", k, i, ov[k], od[k], DW'(i));
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    idle();
    ordy[1] = 1'b0;
    iv[1] = 1'b1;
    id[1] = DW'(8'hAA);
    tick();
    id[1] = DW'(8'hBB);
    tick();
    n_tests++;
    if (occ[1] !== 2'd2 || ir[1] !== 1'b0 || od[1] !== DW'(8'hAA)) begin
      n_fail++;
      $display("FAIL bp_full got occ=%0d rdy=%b d=%h, required 2/0/aa", occ[1], ir[1], od[1]);
    end
    iv[1] = 1'b0;
    ordy[1] = 1'b1;
    #1;
    n_tests++;
    if (ir[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready_registered got rdy=%b, required 0", ir[1]);
    end
    tick();
    n_tests++;
    if (occ[1] !== 2'd1 || od[1] !== DW'(8'hBB)) begin
      n_fail++;
      $display("FAIL bp_one got occ=%0d d=%h, required 1/bb", occ[1], od[1]);
    end
    tick();
    n_tests++;
    if (occ[1] !== 2'd0 || ov[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty got occ=%0d v=%b, required 0/0", occ[1], ov[1]);
    end
    drain();
  endtask

  task automatic test_flush();
    idle();
    ordy[1] = 1'b0;
    iv[1] = 1'b1;
    id[1] = DW'(8'h33);
    tick();
    id[1] = DW'(8'h44);
    tick();
    flush = 1'b1;
    id[1] = DW'(8'hCC);
    tick();
    n_tests++;
    if (occ[1] !== 2'd0 || ov[1] !== 1'b0 || od[1] !== '0) begin
      n_fail++;
      $display("FAIL flush_full got occ=%0d v=%b d=%h, required 0/0/0", occ[1], ov[1], od[1]);
    end
    // Flush in ONE with a real input handshake and an output handshake in the same cycle.
    idle();
    for (int k = 0; k < 2; k++) begin
      ordy[k] = 1'b0;
      iv[k] = 1'b1;
      id[k] = DW'(8'h55);
    end
    tick();
    flush = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ordy[k] = 1'b1;
      id[k] = DW'(8'hCC);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (occ[k] !== 2'd0 || ov[k] !== 1'b0 || od[k] !== '0) begin
        n_fail++;
        $display("FAIL flush_one[skid=%0d] got occ=%0d v=%b d=%h, required 0/0/0", k, occ[k], ov[k], od[k]);
      end
    end
    drain();
  endtask

  task automatic test_simultaneous(int k);
    idle();
    ordy[k] = 1'b0;
    iv[k] = 1'b1;
    id[k] = DW'(8'h11);
    tick();
    ordy[k] = 1'b1;
    id[k] = DW'(8'h22);
    tick();
    n_tests++;
    if (od[k] !== DW'(8'h22) || occ[k] !== 2'd1 || ov[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL simul[skid=%0d] got d=%h occ=%0d v=%b, required 22/1/1", k, od[k], occ[k], ov[k]);
    end
    drain();
  endtask

  task automatic test_random();
    logic          stall  [2];
    logic [DW-1:0] prev_d [2];
    idle();
    for (int c = 0; c < 10000; c++) begin
      flush = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        // A beat offered but not taken stays offered with the same payload.
        if (!(iv[k] && !ir[k])) begin
          iv[k] = ($urandom_range(0, 99) < 60);
          id[k] = {$urandom, $urandom};
        end
        ordy[k] = ($urandom_range(0, 99) < 55);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        stall[k]  = ov[k] && !ordy[k] && !flush;
        prev_d[k] = od[k];
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        if (stall[k]) begin
          n_tests++;
          if (ov[k] !== 1'b1 || od[k] !== prev_d[k]) begin
            n_fail++;
            $display("FAIL stall_stable[skid=%0d] got v=%b d=%h, required v=1 d=%h", k, ov[k], od[k], prev_d[k]);
          end
        end
        n_tests++;
        if (occ[k] > ((k == 1) ? 2'd2 : 2'd1)) begin
          n_fail++;
          $display("FAIL occ_bound[skid=%0d] got %0d", k, occ[k]);
        end
      end
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_stream(1);
    test_stream(0);
    test_backpressure();
    test_flush();
    test_simultaneous(1);
    test_simultaneous(0);
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
